hazard_scoreboard: RTL and testbench

- Parametrised hazard-detection unit for the in-order MIPS-style pipeline; sits between the ID stage and the IF/ID, PC and ID/EX control muxes.
- Keeps a shift-register scoreboard of destination registers in flight through STAGES stages after ID.
- Depending on mode, it either stalls on any RAW dependency or resolves dependencies with forwarding selects, stalling only on load-use.
- Also counts stall cycles for performance measurement.

---
 rtl/hazard_scoreboard_pkg.sv | 38 +++
 rtl/hazard_scoreboard_if.sv | 38 +++
 rtl/hazard_scoreboard_match.sv | 45 ++++
 rtl/hazard_scoreboard.sv | 96 +++++++++
 tb/tb_hazard_scoreboard.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg
// Shared definitions for the hazard scoreboard slice. It holds the register
// address width, the forwarding-select encoding and the scoreboard entry
// record.
// Ports: none (package).
package hazard_scoreboard_pkg;

    localparam int REG_W = 5;
    localparam int SEL_W = 3;

    // Forwarding-select encoding: FWD_RF reads the register file, and
    // FWD_Ek takes the operand from scoreboard entry k.
    localparam logic [SEL_W-1:0] FWD_RF = 3'd0;
    localparam logic [SEL_W-1:0] FWD_E0 = 3'd1;
    localparam logic [SEL_W-1:0] FWD_E1 = 3'd2;
    localparam logic [SEL_W-1:0] FWD_E2 = 3'd3;
    localparam logic [SEL_W-1:0] FWD_E3 = 3'd4;

    // One in-flight instruction, as seen by the hazard logic.
    typedef struct packed {
        logic             wen;
        logic [REG_W-1:0] rd;
        logic             is_load;
    } sb_entry_t;

    // Maps a scoreboard index to the matching forwarding select.
    function automatic logic [SEL_W-1:0] fwdSelFromIndex(input logic [1:0] idx);
        logic [SEL_W-1:0] sel;
        case (idx)
            2'd0:    sel = FWD_E0;
            2'd1:    sel = FWD_E1;
            2'd2:    sel = FWD_E2;
            default: sel = FWD_E3;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if
// Groups the ID-stage request signals and the stall/forward controls that
// pass between the decode stage and the hazard scoreboard.
// master: the ID stage. It drives id_* and flush and reads the controls.
// slave : the scoreboard. It reads id_* and flush and drives
//         pc_write, ifid_write, bubble, fwd_a_sel, fwd_b_sel and stall_count.
interface hazard_scoreboard_if #(
    parameter int CNT_W = 16
);
    import hazard_scoreboard_pkg::*;

    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rt;
    logic             id_wen;
    logic [REG_W-1:0] id_rd;
    logic             id_is_load;
    logic             flush;

    logic             pc_write;
    logic             ifid_write;
    logic             bubble;
    logic [SEL_W-1:0] fwd_a_sel;
    logic [SEL_W-1:0] fwd_b_sel;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rt, id_wen, id_rd, id_is_load, flush,
        input  pc_write, ifid_write, bubble, fwd_a_sel, fwd_b_sel, stall_count
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rt, id_wen, id_rd, id_is_load, flush,
        output pc_write, ifid_write, bubble, fwd_a_sel, fwd_b_sel, stall_count
    );

endinterface

// File: rtl/hazard_scoreboard_match.sv
// hazard_match
// Purely combinational. It compares one source register against every
// scoreboard entry.
// Ports:
//   i_entries          scoreboard contents; entry 0 is the instruction in EX
//   i_src              source register being read in ID
//   i_src_used         the source is actually read by the instruction
//   o_hit              some entry will write i_src
//   o_hit_is_load_at_0 entry 0 is a load that writes i_src
//   o_lowest_index     youngest matching entry (valid only with o_hit)
module hazard_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  sb_entry_t [STAGES-1:0] i_entries,
    input  logic [REG_W-1:0]       i_src,
    input  logic                   i_src_used,
    output logic                   o_hit,
    output logic                   o_hit_is_load_at_0,
    output logic [1:0]             o_lowest_index
);

    logic w_srcLive;

    // $0 is hard-wired to zero, so it is never a real dependency.
    assign w_srcLive = i_src_used && (i_src != '0);

    // The scan runs from the oldest entry to the youngest, so the last
    // assignment is the youngest producer.
    always_comb begin
        o_hit          = 1'b0;
        o_lowest_index = 2'd0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (w_srcLive && i_entries[k].wen && (i_entries[k].rd == i_src)) begin
                o_hit          = 1'b1;
                o_lowest_index = 2'(k);
            end
        end
    end

    assign o_hit_is_load_at_0 = w_srcLive && i_entries[0].wen &&
                                (i_entries[0].rd == i_src) && i_entries[0].is_load;

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// Hazard-detection unit for the in-order pipeline. It tracks the destination
// registers of the STAGES instructions that have left ID. From these it
// either stalls on any RAW dependency (FWD_EN=0) or produces forwarding
// selects and stalls only on load-use (FWD_EN=1). It also keeps a
// saturating count of stall cycles.
// Parameters: STAGES (1..4), FWD_EN (0/1), CNT_W (stall-counter width).
// The register width comes from hazard_scoreboard_pkg.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  slave side of hazard_scoreboard_if. It carries the ID inputs, the
//        flush input, pc_write/ifid_write/bubble, the forwarding selects
//        and stall_count.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int STAGES = 2,
    parameter int FWD_EN = 0,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    hazard_scoreboard_if.slave  bus
);

    localparam bit FWD_MODE = (FWD_EN != 0);

    sb_entry_t [STAGES-1:0] r_sb;
    logic [CNT_W-1:0]       r_stallCount;

    logic       w_rsHit;
    logic       w_rsLoad0;
    logic [1:0] w_rsIdx;
    logic       w_rtHit;
    logic       w_rtLoad0;
    logic [1:0] w_rtIdx;
    logic       w_hazard;

    hazard_match #(.STAGES(STAGES)) u_matchRs (
        .i_entries          (r_sb),
        .i_src              (bus.id_rs),
        .i_src_used         (1'b1),
        .o_hit              (w_rsHit),
        .o_hit_is_load_at_0 (w_rsLoad0),
        .o_lowest_index     (w_rsIdx)
    );

    hazard_match #(.STAGES(STAGES)) u_matchRt (
        .i_entries          (r_sb),
        .i_src              (bus.id_rt),
        .i_src_used         (bus.id_uses_rt),
        .o_hit              (w_rtHit),
        .o_hit_is_load_at_0 (w_rtLoad0),
        .o_lowest_index     (w_rtIdx)
    );

    // Forwarding only has to stall when the producer in EX is a load. Its
    // data is not ready until after MEM. A flush removes the consumer, so
    // there is nothing left to stall for.
    assign w_hazard = bus.id_valid && !bus.flush &&
                      (FWD_MODE ? (w_rsLoad0 || w_rtLoad0) : (w_rsHit || w_rtHit));

    assign bus.pc_write    = !w_hazard;
    assign bus.ifid_write  = !w_hazard;
    assign bus.bubble      = w_hazard;
    assign bus.stall_count = r_stallCount;

    // The selects are meaningless during a stall, because the bubble goes
    // to EX, so they are held at the register-file encoding.
    assign bus.fwd_a_sel = (FWD_MODE && !w_hazard && w_rsHit) ? fwdSelFromIndex(w_rsIdx) : FWD_RF;
    assign bus.fwd_b_sel = (FWD_MODE && !w_hazard && w_rtHit) ? fwdSelFromIndex(w_rtIdx) : FWD_RF;

    // The scoreboard advances every cycle, even while stalled. A stalled,
    // squashed or empty ID slot inserts an all-zero bubble, so a dependency
    // drains within STAGES cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sb         <= '0;
            r_stallCount <= '0;
        end else begin
            for (int k = 1; k < STAGES; k++) begin
                r_sb[k] <= r_sb[k-1];
            end
            if (w_hazard || bus.flush || !bus.id_valid) begin
                r_sb[0] <= '0;
            end else begin
                r_sb[0] <= '{wen: bus.id_wen, rd: bus.id_rd, is_load: bus.id_is_load};
            end
            if (w_hazard && (r_stallCount != '1)) begin
                r_stallCount <= r_stallCount + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
// Drives two scoreboards with hand-computed vectors. dut0 runs in stall-only
// mode with a 4-bit counter. dut1 runs in forwarding mode with a 16-bit
// counter. Each vector row is one clock cycle.
module tb_hazard_scoreboard;

    logic clk;
    logic rst;

    int checks   = 0;
    int failures = 0;

    hazard_scoreboard_if #(.CNT_W(4))  if0 ();
    hazard_scoreboard_if #(.CNT_W(16)) if1 ();

    hazard_scoreboard #(.STAGES(2), .FWD_EN(0), .CNT_W(4)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    hazard_scoreboard #(.STAGES(2), .FWD_EN(1), .CNT_W(16)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    // Free-running 10ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         dut;
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       usesRt;
        logic       wen;
        logic [4:0] rd;
        logic       isLoad;
        logic       flush;
        logic       expHz;
        logic [2:0] expA;
        logic [2:0] expB;
        int         expCnt;
    } vec_t;

    vec_t vecs[$];

    // Builds one vector row from compact integer arguments.
    function automatic vec_t mk(int dut, int valid, int rs, int rt, int usesRt, int wen,
                                int rd, int isLoad, int flush, int expHz, int expA,
                                int expB, int expCnt);
        vec_t v;
        v.dut    = dut;
        v.valid  = 1'(valid);
        v.rs     = 5'(rs);
        v.rt     = 5'(rt);
        v.usesRt = 1'(usesRt);
        v.wen    = 1'(wen);
        v.rd     = 5'(rd);
        v.isLoad = 1'(isLoad);
        v.flush  = 1'(flush);
        v.expHz  = 1'(expHz);
        v.expA   = 3'(expA);
        v.expB   = 3'(expB);
        v.expCnt = expCnt;
        return v;
    endfunction

    // Builds an empty ID-slot row for one DUT.
    function automatic vec_t idle(int dut, int expCnt);
        return mk(dut, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, expCnt);
    endfunction

    // Compares one observed value against its expected value.
    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Puts a vector on its DUT's interface and leaves the other DUT idle.
    task automatic applyStimulus(input vec_t v);
        if0.id_valid = 1'b0; if0.id_rs = '0; if0.id_rt = '0; if0.id_uses_rt = 1'b0;
        if0.id_wen = 1'b0; if0.id_rd = '0; if0.id_is_load = 1'b0; if0.flush = 1'b0;
        if1.id_valid = 1'b0; if1.id_rs = '0; if1.id_rt = '0; if1.id_uses_rt = 1'b0;
        if1.id_wen = 1'b0; if1.id_rd = '0; if1.id_is_load = 1'b0; if1.flush = 1'b0;
        if (v.dut == 0) begin
            if0.id_valid = v.valid; if0.id_rs = v.rs; if0.id_rt = v.rt; if0.id_uses_rt = v.usesRt;
            if0.id_wen = v.wen; if0.id_rd = v.rd; if0.id_is_load = v.isLoad; if0.flush = v.flush;
        end else begin
            if1.id_valid = v.valid; if1.id_rs = v.rs; if1.id_rt = v.rt; if1.id_uses_rt = v.usesRt;
            if1.id_wen = v.wen; if1.id_rd = v.rd; if1.id_is_load = v.isLoad; if1.flush = v.flush;
        end
    endtask

    // Compares the selected DUT's controls against the vector's expectations.
    task automatic checkOutput(input vec_t v, input string tag);
        logic       pcw, ifw, bub;
        logic [2:0] a, b;
        logic [31:0] cnt;
        if (v.dut == 0) begin
            pcw = if0.pc_write; ifw = if0.ifid_write; bub = if0.bubble;
            a = if0.fwd_a_sel; b = if0.fwd_b_sel; cnt = 32'(if0.stall_count);
        end else begin
            pcw = if1.pc_write; ifw = if1.ifid_write; bub = if1.bubble;
            a = if1.fwd_a_sel; b = if1.fwd_b_sel; cnt = 32'(if1.stall_count);
        end
        checkVal({tag, ".pc_write"},    32'(pcw), 32'(!v.expHz));
        checkVal({tag, ".ifid_write"},  32'(ifw), 32'(!v.expHz));
        checkVal({tag, ".bubble"},      32'(bub), 32'(v.expHz));
        checkVal({tag, ".fwd_a_sel"},   32'(a),   32'(v.expA));
        checkVal({tag, ".fwd_b_sel"},   32'(b),   32'(v.expB));
        checkVal({tag, ".stall_count"}, cnt,      32'(v.expCnt));
    endtask

    // One clock cycle: drive just after the edge, then compare before the next edge.
    task automatic runRow(input vec_t v, input string tag);
        applyStimulus(v);
        #2;
        checkOutput(v, tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int model;

        rst = 1'b1;
        applyStimulus(idle(0, 0));
        #12;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset state of both configurations.
        runRow(idle(0, 0), "reset.dut0");
        runRow(idle(1, 0), "reset.dut1");

        // dut0, stall-only: producer-consumer stalls for two cycles.
        vecs.push_back(mk(0, 1, 1, 2, 1, 1, 3, 0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 3, 4, 1, 1, 5, 0, 0,  1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 3, 4, 1, 1, 5, 0, 0,  1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 3, 4, 1, 1, 5, 0, 0,  0, 0, 0, 2));
        vecs.push_back(idle(0, 2));
        vecs.push_back(idle(0, 2));
        // dut0: writing $0 and then reading $0 never stalls.
        vecs.push_back(mk(0, 1, 1, 2, 1, 1, 0, 0, 0,  0, 0, 0, 2));
        vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 2));
        vecs.push_back(idle(0, 2));
        vecs.push_back(idle(0, 2));
        // dut0: rt is ignored when unused. An entry-1 match stalls once.
        vecs.push_back(mk(0, 1, 1, 2, 1, 1, 7, 0, 0,  0, 0, 0, 2));
        vecs.push_back(mk(0, 1, 1, 7, 0, 0, 0, 0, 0,  0, 0, 0, 2));
        vecs.push_back(mk(0, 1, 1, 7, 1, 0, 0, 0, 0,  1, 0, 0, 2));
        vecs.push_back(mk(0, 1, 1, 7, 1, 0, 0, 0, 0,  0, 0, 0, 3));
        vecs.push_back(idle(0, 3));
        vecs.push_back(idle(0, 3));
        // dut1, forwarding: EX forward on both operands, then MEM forward.
        vecs.push_back(mk(1, 1, 1, 2, 1, 1, 3, 0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 3, 3, 1, 1, 8, 0, 0,  0, 1, 1, 0));
        vecs.push_back(mk(1, 1, 3, 8, 1, 1, 9, 0, 0,  0, 2, 1, 0));
        vecs.push_back(idle(1, 0));
        vecs.push_back(idle(1, 0));
        // dut1: load-use stalls exactly one cycle, then forwards from entry 1.
        vecs.push_back(mk(1, 1, 1, 5, 0, 1, 5, 1, 0,  0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 5, 1, 1, 10, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 5, 1, 1, 10, 0, 0, 0, 0, 2, 1));
        vecs.push_back(idle(1, 1));
        vecs.push_back(idle(1, 1));
        // dut1: the load with rt unused does not stall. A load in entry 1 forwards.
        vecs.push_back(mk(1, 1, 1, 5, 0, 1, 5, 1, 0,  0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 1, 5, 0, 1, 11, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 5, 0, 0, 0, 0, 0, 0,  0, 2, 0, 1));
        vecs.push_back(idle(1, 1));
        vecs.push_back(idle(1, 1));
        // dut1: a load to $0 followed by a read of $0 neither stalls nor forwards.
        vecs.push_back(mk(1, 1, 1, 2, 1, 1, 0, 1, 0,  0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 1));
        vecs.push_back(idle(1, 1));
        vecs.push_back(idle(1, 1));
        // dut1: two producers of $12 in flight. The youngest (entry 0) wins.
        vecs.push_back(mk(1, 1, 1, 2, 1, 1, 12, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 1, 2, 1, 1, 12, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 12, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
        vecs.push_back(idle(1, 1));
        vecs.push_back(idle(1, 1));
        // dut1: a flush over a load-use removes the stall and still reports the forward.
        vecs.push_back(mk(1, 1, 1, 2, 0, 1, 5, 1, 0,  0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 5, 0, 0, 1, 6, 0, 1,  0, 1, 0, 1));
        vecs.push_back(idle(1, 1));
        vecs.push_back(idle(1, 1));

        foreach (vecs[i]) begin
            runRow(vecs[i], $sformatf("row%0d", i));
        end

        // Flush in the stall cycle: no stall, and the flushed sub ($4)
        // never enters the scoreboard. The older add ($3) keeps moving.
        runRow(mk(0, 1, 1, 2, 1, 1, 3, 0, 0,  0, 0, 0, 3), "flush.add");
        runRow(mk(0, 1, 3, 0, 0, 1, 4, 0, 1,  0, 0, 0, 3), "flush.sub");
        runRow(mk(0, 1, 4, 3, 1, 0, 0, 0, 0,  1, 0, 0, 3), "flush.rdE1");
        runRow(mk(0, 1, 4, 3, 1, 0, 0, 0, 0,  0, 0, 0, 4), "flush.noRd4");
        runRow(idle(0, 4), "flush.idle0");
        runRow(idle(0, 4), "flush.idle1");

        // Reset asserted in the middle of a stall releases it immediately.
        runRow(mk(0, 1, 1, 2, 1, 1, 3, 0, 0, 0, 0, 0, 4), "rstmid.add");
        applyStimulus(mk(0, 1, 3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4));
        #2;
        checkOutput(mk(0, 1, 3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4), "rstmid.stall");
        rst = 1'b1;
        #1;
        checkVal("rstmid.pc_write",    32'(if0.pc_write),    32'd1);
        checkVal("rstmid.ifid_write",  32'(if0.ifid_write),  32'd1);
        checkVal("rstmid.bubble",      32'(if0.bubble),      32'd0);
        checkVal("rstmid.stall_count", 32'(if0.stall_count), 32'd0);
        checkVal("rstmid.dut1_count",  32'(if1.stall_count), 32'd0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        runRow(idle(0, 0), "rstmid.idle0");
        runRow(idle(0, 0), "rstmid.idle1");

        // Saturation: ten producer/consumer pairs make 20 stall cycles on a
        // 4-bit counter, and the counter must stick at 15.
        model = 0;
        for (int it = 0; it < 10; it++) begin
            runRow(mk(0, 1, 1, 2, 1, 1, 3, 0, 0, 0, 0, 0, model), $sformatf("sat%0d.add", it));
            for (int s = 0; s < 3; s++) begin
                int h;
                h = (s < 2) ? 1 : 0;
                runRow(mk(0, 1, 3, 0, 0, 0, 0, 0, 0, h, 0, 0, model), $sformatf("sat%0d.sub%0d", it, s));
                if (h == 1 && model < 15) model++;
            end
        end
        checkVal("sat.final", 32'(if0.stall_count), 32'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
